byte_data_memory: RTL and testbench

Parametrised, byte-addressable data memory for the ARM datapath: the successor to the single-word, fixed-depth data memory. Accepts one load/store request per cycle over a valid/ready handshake and supports byte, halfword and word sizes with sign/zero extension. Returns every request's result with a response handshake, and flags out-of-range accesses. Sits between the MEM pipeline stage and the load writeback mux.

---
 rtl/byte_data_memory_pkg.sv | 31 +++
 rtl/byte_data_memory_lane.sv | 84 ++++++++
 rtl/byte_data_memory.sv | 154 +++++++++++++++
 tb/tb_byte_data_memory.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/byte_data_memory_pkg.sv
// byte_data_memory_pkg
// Shared encodings and helpers for the byte-addressable data memory:
// access-size codes, controller states and byte-lane geometry.
package byte_data_memory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } MemState;

    // Lane geometry for the standard 32-bit datapath.
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int OFFSET_BITS        = $clog2(BYTES_PER_WORD);

    // Lane geometry for an arbitrary word width (multiple of 16).
    function automatic int bytesPerWord(input int dataWidth);
        return dataWidth / 8;
    endfunction

    function automatic int offsetBits(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/byte_data_memory_lane.sv
// byte_data_memory_lane
// Combinational byte-lane logic. The load side extracts the lanes chosen
// by size/offset from a memory word and zero- or sign-extends them; the
// store side shifts the right-justified store data into place and merges
// it over the old word, also producing the byte-enable mask.
// Optional feature macro: BYTE_DATA_MEMORY_ALIGN_CHECK_EN -- when defined,
// misaligned halfword/word accesses are reported on alignFault; otherwise
// the offset is silently forced to natural alignment.
module byte_data_memory_lane
    import byte_data_memory_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int LANES      = DATA_WIDTH / 8,
    localparam int OFF_BITS   = $clog2(DATA_WIDTH / 8)
) (
    input  logic [1:0]            size,
    input  logic [OFF_BITS-1:0]   offset,
    input  logic                  isSigned,
    input  logic [DATA_WIDTH-1:0] memWord,
    input  logic [DATA_WIDTH-1:0] storeData,
    output logic [DATA_WIDTH-1:0] loadData,
    output logic [DATA_WIDTH-1:0] mergedWord,
    output logic [LANES-1:0]      byteEn,
    output logic                  alignFault
);

    logic [OFF_BITS-1:0]   alignedOffset;
    logic [LANES-1:0]      sizeMask;
    logic [DATA_WIDTH-1:0] shiftedWord;
    logic [DATA_WIDTH-1:0] shiftedData;

    // Force the offset to the natural alignment of the access and pick the lane mask.
    always_comb begin
        alignedOffset = offset;
        sizeMask      = '0;
        case (size)
            SIZE_BYTE: sizeMask = LANES'(1);
            SIZE_HALF: begin
                sizeMask      = LANES'(3);
                alignedOffset = offset & ~OFF_BITS'(1);
            end
            SIZE_WORD: begin
                sizeMask      = '1;
                alignedOffset = '0;
            end
            default: sizeMask = '0;
        endcase
    end

    assign byteEn      = sizeMask << alignedOffset;
    assign shiftedWord = memWord >> {alignedOffset, 3'b000};
    assign shiftedData = storeData << {alignedOffset, 3'b000};

    // Load side: right-justify the selected lanes, then zero- or sign-extend.
    always_comb begin
        loadData = '0;
        case (size)
            SIZE_BYTE: loadData = isSigned ? DATA_WIDTH'($signed(shiftedWord[7:0]))
                                           : DATA_WIDTH'(shiftedWord[7:0]);
            SIZE_HALF: loadData = isSigned ? DATA_WIDTH'($signed(shiftedWord[15:0]))
                                           : DATA_WIDTH'(shiftedWord[15:0]);
            SIZE_WORD: loadData = memWord;
            default:   loadData = '0;
        endcase
    end

    // Store side: new bytes on enabled lanes, old bytes everywhere else.
    always_comb begin
        mergedWord = memWord;
        for (int i = 0; i < LANES; i++) begin
            if (byteEn[i]) begin
                mergedWord[i*8 +: 8] = shiftedData[i*8 +: 8];
            end
        end
    end

`ifdef BYTE_DATA_MEMORY_ALIGN_CHECK_EN
    assign alignFault = ((size == SIZE_HALF) && offset[0]) ||
                        ((size == SIZE_WORD) && (offset != '0));
`else
    assign alignFault = 1'b0;
`endif

endmodule

// File: rtl/byte_data_memory.sv
// byte_data_memory
// Byte-addressable data memory between the MEM stage and load writeback.
// One load/store per cycle over req valid/ready; each request yields one
// registered response held until rsp_ready. After reset the array is
// zeroed by a one-word-per-cycle CLEAR sweep before requests are taken.
// Optional feature macro: BYTE_DATA_MEMORY_ALIGN_CHECK_EN (misalignment faults).
module byte_data_memory
    import byte_data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault
);

    localparam int LANES    = bytesPerWord(DATA_WIDTH);
    localparam int OFF_BITS = offsetBits(DATA_WIDTH);
    localparam int IDX_BITS = $clog2(DEPTH_WORDS);
    localparam int WIDX_W   = ADDR_WIDTH - OFF_BITS;

    MemState state;
    MemState nextState;

    logic [IDX_BITS-1:0]   clearCnt;
    logic                  clearLast;
    logic                  reqReady;
    logic                  accept;

    logic [WIDX_W-1:0]     wordIndex;
    logic [IDX_BITS-1:0]   memIdx;
    logic [OFF_BITS-1:0]   laneOffset;
    logic                  inRange;
    logic                  alignFault;
    logic                  reqFault;
    logic                  doStore;

    logic [DATA_WIDTH-1:0] memWord;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [LANES-1:0]      byteEn;

    logic [DATA_WIDTH-1:0] rspRdata;
    logic                  rspFault;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Address decode: word index above the array depth is out of range.
    assign wordIndex  = req_addr[ADDR_WIDTH-1:OFF_BITS];
    assign laneOffset = req_addr[OFF_BITS-1:0];
    assign memIdx     = wordIndex[IDX_BITS-1:0];
    assign inRange    = (wordIndex >> IDX_BITS) == '0;
    assign memWord    = mem[memIdx];

    byte_data_memory_lane #(
        .DATA_WIDTH(DATA_WIDTH)
    ) laneLogic (
        .size      (req_size),
        .offset    (laneOffset),
        .isSigned  (req_signed),
        .memWord   (memWord),
        .storeData (req_wdata),
        .loadData  (loadData),
        .mergedWord(mergedWord),
        .byteEn    (byteEn),
        .alignFault(alignFault)
    );

    assign reqFault  = !inRange || (req_size == SIZE_RSVD) || alignFault;
    assign accept    = req_valid && reqReady;
    assign doStore   = accept && req_write && !reqFault;
    assign clearLast = (clearCnt == IDX_BITS'(DEPTH_WORDS - 1));

    // State register and clear-sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            clearCnt <= '0;
        end else begin
            state <= nextState;
            if (state == ST_CLEAR) begin
                clearCnt <= clearCnt + 1'b1;
            end
        end
    end

    // Next state and request-side ready; ready in RESP passes rsp_ready straight through.
    always_comb begin
        nextState = state;
        reqReady  = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clearLast) begin
                    nextState = ST_IDLE;
                end
            end
            ST_IDLE: begin
                reqReady = 1'b1;
                if (req_valid) begin
                    nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                reqReady = rsp_ready;
                if (rsp_ready && !req_valid) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_CLEAR;
        endcase
    end

    // Capture the response at the accept edge; stores and faults return zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rspRdata <= '0;
            rspFault <= 1'b0;
        end else if (accept) begin
            rspRdata <= (req_write || reqFault) ? '0 : loadData;
            rspFault <= reqFault;
        end
    end

    // Array writes: zero sweep during CLEAR, otherwise byte-enabled stores.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clearCnt] <= '0;
        end else if (doStore) begin
            for (int i = 0; i < LANES; i++) begin
                if (byteEn[i]) begin
                    mem[memIdx][i*8 +: 8] <= mergedWord[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready = reqReady;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rspRdata;
    assign rsp_fault = rspFault;

endmodule

// File: tb/tb_byte_data_memory.sv
// tb_byte_data_memory
// Directed, scoreboard-checked bench for byte_data_memory. Expected
// responses are queued at each accept and compared when the response is
// consumed. Honours BYTE_DATA_MEMORY_ALIGN_CHECK_EN for misaligned cases.
module tb_byte_data_memory;
    import byte_data_memory_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        fault;
    } Expect;

    Expect expQ[$];
    int    vecCount  = 0;
    int    missCount = 0;

    byte_data_memory #(
        .DATA_WIDTH (32),
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one request and wait (bounded) for it to be accepted; queue its expected response.
    task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expFault, output int waited);
        Expect e;
        logic  accepted;
        e.tag      = tag;
        e.rdata    = expRdata;
        e.fault    = expFault;
        accepted   = 1'b0;
        waited     = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (req_ready === 1'b1) accepted = 1'b1;
            else waited++;
        end
        if (accepted) expQ.push_back(e);
        checkOutput({tag, " accepted"}, 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count cycles with req_ready low after reset release.
    task automatic waitClear(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput(tag, 32'(n), 32'd256);
    endtask

    // Response monitor: compare each consumed response against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checkOutput("scoreboard has entry", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                Expect e;
                e = expQ.pop_front();
                checkOutput({e.tag, " rdata"}, rsp_rdata, e.rdata);
                checkOutput({e.tag, " fault"}, 32'(rsp_fault), 32'(e.fault));
            end
        end
    end

    initial begin
        int w;
        logic [31:0] hExp;
        logic        hFault;
        logic [31:0] misWordExp;
        logic        misWordFault;

`ifdef BYTE_DATA_MEMORY_ALIGN_CHECK_EN
        hExp = 32'h0; hFault = 1'b1;
        misWordExp = 32'h0; misWordFault = 1'b1;
`else
        hExp = 32'h0000BEEF; hFault = 1'b0;
        misWordExp = 32'h80ADBEEF; misWordFault = 1'b0;
`endif

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = SIZE_WORD;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;

        #3;
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset rsp_fault", 32'(rsp_fault), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        waitClear("clear cycles");

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus($sformatf("cleared word %0d", i), 1'b0, SIZE_WORD, 1'b0, 32'(i * 4), 32'h0, 32'h0, 1'b0, w);
        end
        idleCycles(2);

        applyStimulus("store word @08", 1'b1, SIZE_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, w);
        applyStimulus("load word @08", 1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, w);
        checkOutput("back-to-back load stall", 32'(w), 32'd0);

        applyStimulus("store byte @0B", 1'b1, SIZE_BYTE, 1'b0, 32'h0B, 32'h55555580, 32'h0, 1'b0, w);
        applyStimulus("signed byte @0B", 1'b0, SIZE_BYTE, 1'b1, 32'h0B, 32'h0, 32'hFFFFFF80, 1'b0, w);
        applyStimulus("unsigned byte @0B", 1'b0, SIZE_BYTE, 1'b0, 32'h0B, 32'h0, 32'h00000080, 1'b0, w);
        applyStimulus("word after byte @08", 1'b0, SIZE_WORD, 1'b1, 32'h08, 32'h0, 32'h80ADBEEF, 1'b0, w);
        idleCycles(2);

        rsp_ready = 1'b0;
        applyStimulus("held load", 1'b0, SIZE_BYTE, 1'b1, 32'h0B, 32'h0, 32'hFFFFFF80, 1'b0, w);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("hold %0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("hold %0d rsp_rdata", k), rsp_rdata, 32'hFFFFFF80);
            checkOutput($sformatf("hold %0d req_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("req_ready follows rsp_ready", 32'(req_ready), 32'd1);
        applyStimulus("pending load @08", 1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 32'h80ADBEEF, 1'b0, w);
        checkOutput("pending accepted same edge", 32'(w), 32'd0);

        applyStimulus("store word @00", 1'b1, SIZE_WORD, 1'b0, 32'h00, 32'h12345678, 32'h0, 1'b0, w);
        applyStimulus("store @400 range", 1'b1, SIZE_WORD, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1, w);
        applyStimulus("reserved store @00", 1'b1, SIZE_RSVD, 1'b0, 32'h00, 32'hFFFFFFFF, 32'h0, 1'b1, w);
        applyStimulus("load @00 after faults", 1'b0, SIZE_WORD, 1'b0, 32'h00, 32'h0, 32'h12345678, 1'b0, w);
        applyStimulus("load @408 range", 1'b0, SIZE_WORD, 1'b0, 32'h408, 32'h0, 32'h0, 1'b1, w);
        applyStimulus("reserved load @08", 1'b0, SIZE_RSVD, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1, w);

        applyStimulus("half load @09", 1'b0, SIZE_HALF, 1'b0, 32'h09, 32'h0, hExp, hFault, w);
        applyStimulus("word load @0A", 1'b0, SIZE_WORD, 1'b0, 32'h0A, 32'h0, misWordExp, misWordFault, w);
        applyStimulus("signed half @08", 1'b0, SIZE_HALF, 1'b1, 32'h08, 32'h0, 32'hFFFFBEEF, 1'b0, w);
        applyStimulus("unsigned half @0A", 1'b0, SIZE_HALF, 1'b0, 32'h0A, 32'h0, 32'h000080AD, 1'b0, w);
        applyStimulus("signed byte @09", 1'b0, SIZE_BYTE, 1'b1, 32'h09, 32'h0, 32'hFFFFFFBE, 1'b0, w);
        applyStimulus("store half @0E", 1'b1, SIZE_HALF, 1'b0, 32'h0E, 32'hAAAA1234, 32'h0, 1'b0, w);
        applyStimulus("word after half @0C", 1'b0, SIZE_WORD, 1'b0, 32'h0C, 32'h0, 32'h12340000, 1'b0, w);
        idleCycles(2);

        rsp_ready = 1'b0;
        applyStimulus("load before reset", 1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 32'h80ADBEEF, 1'b0, w);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid-resp reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid-resp reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("mid-resp reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("mid-resp reset rsp_fault", 32'(rsp_fault), 32'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        reset_n   = 1'b1;
        waitClear("clear restart cycles");
        applyStimulus("load @08 after reclear", 1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, w);
        applyStimulus("load @00 after reclear", 1'b0, SIZE_WORD, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, w);
        idleCycles(3);

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
